// File: rtl/forward_activation_if.sv
// Handshake bundle between the accumulator producer, forward_activation and the state consumer.
// master = environment side (drives accumulators, takes states), slave = forward_activation.
interface forward_activation_if #(
  parameter int NC = 11,
  parameter int WA = 8,
  parameter int WF = 5
);
  logic                 iValid_AM_Accum;
  logic                 oReady_AM_Accum;
  logic [NC*WA-1:0]     iData_AM_Accum;
  logic                 oValid_BM_State;
  logic                 iReady_BM_State;
  logic [NC*WF-1:0]     oData_BM_State;
  logic [NC-1:0]        oData_BM_Deriv;

  modport master (
    output iValid_AM_Accum,
    output iData_AM_Accum,
    output iReady_BM_State,
    input  oReady_AM_Accum,
    input  oValid_BM_State,
    input  oData_BM_State,
    input  oData_BM_Deriv
  );

  modport slave (
    input  iValid_AM_Accum,
    input  iData_AM_Accum,
    input  iReady_BM_State,
    output oReady_AM_Accum,
    output oValid_BM_State,
    output oData_BM_State,
    output oData_BM_Deriv
  );
endinterface

// File: rtl/forward_activation.sv
// ReLU with saturation to WF-bit signed state plus derivative mask, LANES neurons per cycle.
// Optional macro FORWARD_ACTIVATION_LEAKY_EN maps negative inputs to x>>>2 instead of 0.
module forward_activation #(
  parameter int    NP    = 7,
  parameter int    NC    = 11,
  parameter int    WF    = 5,
  parameter int    LANES = 4,
  parameter string BURST = "yes"
) (
  input  logic                iCLK,
  input  logic                iRST,
  forward_activation_if.slave bus
);
  localparam int WA       = $clog2(NP) + WF;
  localparam int CHUNKS   = (NC + LANES - 1) / LANES;
  localparam int PAD      = CHUNKS * LANES;
  localparam int KW       = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam bit BURST_EN = (BURST == "yes");

  localparam logic signed [WA-1:0] MAX_POS = {{(WA-WF+1){1'b0}}, {(WF-1){1'b1}}};
`ifdef FORWARD_ACTIVATION_LEAKY_EN
  localparam int                   LEAK_SHIFT = 2;
  localparam logic signed [WA-1:0] MIN_NEG    = {{(WA-WF+1){1'b1}}, {(WF-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } fa_state_t;

  fa_state_t           state_r;
  fa_state_t           state_nxt_s;
  logic [KW-1:0]       k_r;
  logic [PAD*WA-1:0]   hold_r;
  logic [NC*WF-1:0]    state_data_r;
  logic [NC-1:0]       deriv_r;
  logic                ready_s;
  logic                valid_s;
  logic                calc_s;
  logic                accept_s;
  logic                last_chunk_s;
  logic [WF:0]         lane_act_s [LANES];

  // Returns {deriv, y}: deriv is set only for strictly positive inputs
  function automatic logic [WF:0] activate(input logic signed [WA-1:0] x);
    logic [WF:0] r;
`ifdef FORWARD_ACTIVATION_LEAKY_EN
    logic signed [WA-1:0] s;
`endif
    r = {(WF+1){1'b0}};
    if (x > MAX_POS) begin
      r = {1'b1, MAX_POS[WF-1:0]};
    end else if (!x[WA-1] && (x != {WA{1'b0}})) begin
      r = {1'b1, x[WF-1:0]};
    end else begin
`ifdef FORWARD_ACTIVATION_LEAKY_EN
      s = x >>> LEAK_SHIFT;
      if (s < MIN_NEG) begin
        r = {1'b0, MIN_NEG[WF-1:0]};
      end else begin
        r = {1'b0, s[WF-1:0]};
      end
`else
      r = {(WF+1){1'b0}};
`endif
    end
    return r;
  endfunction

  assign accept_s     = bus.iValid_AM_Accum && ready_s;
  assign last_chunk_s = (k_r == KW'(CHUNKS - 1));

  // State register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (last_chunk_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = CALC;
        end
      end
      DONE: begin
        if (accept_s) begin
          state_nxt_s = CALC;
        end else if (bus.iReady_BM_State) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM outputs; in burst mode DONE passes downstream ready straight upstream
  always_comb begin
    ready_s = 1'b0;
    valid_s = 1'b0;
    calc_s  = 1'b0;
    case (state_r)
      IDLE: begin
        ready_s = 1'b1;
      end
      CALC: begin
        calc_s = 1'b1;
      end
      DONE: begin
        valid_s = 1'b1;
        ready_s = BURST_EN ? bus.iReady_BM_State : 1'b0;
      end
      default: begin
        ready_s = 1'b0;
      end
    endcase
  end

  // Current chunk always sits in the low lanes of the hold register
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_act_s[l] = activate(hold_r[l*WA +: WA]);
    end
  end

  // Holding register and chunk counter: load on accept, shift one chunk per CALC cycle
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      hold_r <= {(PAD*WA){1'b0}};
      k_r    <= {KW{1'b0}};
    end else if (accept_s) begin
      hold_r <= (PAD*WA)'(bus.iData_AM_Accum);
      k_r    <= {KW{1'b0}};
    end else if (calc_s) begin
      hold_r <= hold_r >> (LANES * WA);
      k_r    <= k_r + KW'(1);
    end else begin
      hold_r <= hold_r;
      k_r    <= k_r;
    end
  end

  // Output registers: element i is owned by lane i%LANES during chunk i/LANES
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_data_r <= {(NC*WF){1'b0}};
      deriv_r      <= {NC{1'b0}};
    end else if (calc_s) begin
      for (int i = 0; i < NC; i++) begin
        if (k_r == KW'(i / LANES)) begin
          state_data_r[i*WF +: WF] <= lane_act_s[i % LANES][WF-1:0];
          deriv_r[i]               <= lane_act_s[i % LANES][WF];
        end
      end
    end
  end

  assign bus.oReady_AM_Accum = ready_s;
  assign bus.oValid_BM_State = valid_s;
  assign bus.oData_BM_State  = state_data_r;
  assign bus.oData_BM_Deriv  = deriv_r;
endmodule
